sid_reg_if: RTL

// - Responder for the host register-write strobe protocol on ui_in/uio_in of tt_um_sid.
// - Captures {we=ui_in[7], rd=ui_in[6], voice=ui_in[4:3], addr=ui_in[2:0]} and data=uio_in.
// - Commits one write per strobe rising edge into per-voice register banks.
// - Drives the voice and ADSR config buses and gate edge pulses. Sits between the pads and the voice/env cores.

---
 rtl/sid_reg_pkg.sv | 43 ++++
 rtl/sid_wr_sync.sv | 54 +++++
 rtl/sid_reg_if.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sid_reg_pkg.sv
// Shared types and constants for the SID host register interface.
// The address map, ctrl bit positions and voice bank layout live here.
package sid_reg_pkg;

  localparam int DEF_NUM_VOICES = 3;
  localparam int FREQ_W         = 16;
  localparam int PW_W           = 12;
  localparam int VOICE_W        = 2;
  localparam int ADDR_W         = 3;

  localparam logic [ADDR_W-1:0] ADDR_FREQ_LO = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_FREQ_HI = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PW_LO   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_PW_HI   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_ATK_DEC = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_SUS_REL = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 3'd6;

  localparam int CTRL_GATE  = 0;
  localparam int CTRL_SYNC  = 1;
  localparam int CTRL_RING  = 2;
  localparam int CTRL_TEST  = 3;
  localparam int CTRL_TRI   = 4;
  localparam int CTRL_SAW   = 5;
  localparam int CTRL_PULSE = 6;
  localparam int CTRL_NOISE = 7;

  // Payload of one host access as captured from the pads.
  typedef struct packed {
    logic [VOICE_W-1:0] voice;
    logic [ADDR_W-1:0]  addr;
    logic [7:0]         data;
  } host_req_t;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [PW_W-1:0]   pw;
    logic [7:0]        atk_dec;
    logic [7:0]        sus_rel;
    logic [7:0]        ctrl;
  } voice_regs_t;

endpackage

// File: rtl/sid_wr_sync.sv
// Pad capture stage: registers ui_in/uio_in every clk and emits a one-cycle write strobe
// on the sampled we rising edge (read strobe only with SID_READBACK_EN); no backpressure.
module sid_wr_sync
  import sid_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output host_req_t  req,
  output logic       wr_stb
`ifdef SID_READBACK_EN
  ,
  output logic       rd_stb
`endif
);

  logic s1_we;
  logic s2_we;

  // Edge tracking runs even with ena low, so a strobe already high when ena rises never commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_we <= 1'b0;
      s2_we <= 1'b0;
      req   <= '0;
    end else begin
      s1_we     <= ui_in[7];
      s2_we     <= s1_we;
      req.voice <= ui_in[4:3];
      req.addr  <= ui_in[2:0];
      req.data  <= uio_in;
    end
  end

  assign wr_stb = s1_we & ~s2_we & ena;

`ifdef SID_READBACK_EN
  logic s1_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rd <= 1'b0;
    end else begin
      s1_rd <= ui_in[6];
    end
  end

  // A combined rd+we access is treated purely as a write.
  assign rd_stb = s1_rd & ~s1_we & ena;
`endif

endmodule

// File: rtl/sid_reg_if.sv
// SID host register responder: per-voice banks, gate edge pulses and optional readback (SID_READBACK_EN).
// Writes land 2 clk after we is sampled high, reads 2 clk after rd; the host is never stalled.
module sid_reg_if
  import sid_reg_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [7:0]                   ui_in,
  input  logic [7:0]                   uio_in,
  output logic [7:0]                   uio_out,
  output logic [7:0]                   uio_oe,
  output logic [NUM_VOICES*FREQ_W-1:0] freq_o,
  output logic [NUM_VOICES*PW_W-1:0]   pw_o,
  output logic [NUM_VOICES*8-1:0]      atk_dec_o,
  output logic [NUM_VOICES*8-1:0]      sus_rel_o,
  output logic [NUM_VOICES*8-1:0]      ctrl_o,
  output logic [NUM_VOICES-1:0]        gate_rise_o,
  output logic [NUM_VOICES-1:0]        gate_fall_o
);

  host_req_t   req;
  logic        wr_stb;
  voice_regs_t bank [NUM_VOICES];

`ifdef SID_READBACK_EN
  logic rd_stb;
`endif

  sid_wr_sync u_wr_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .req    (req),
    .wr_stb (wr_stb)
`ifdef SID_READBACK_EN
    ,
    .rd_stb (rd_stb)
`endif
  );

  // Bytes commit independently; the voice core sees half-written freq/pw values by design.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        bank[v] <= '0;
      end
      gate_rise_o <= '0;
      gate_fall_o <= '0;
    end else begin
      gate_rise_o <= '0;
      gate_fall_o <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (wr_stb && (req.voice == VOICE_W'(v))) begin
          case (req.addr)
            ADDR_FREQ_LO: bank[v].freq[7:0]  <= req.data;
            ADDR_FREQ_HI: bank[v].freq[15:8] <= req.data;
            ADDR_PW_LO:   bank[v].pw[7:0]    <= req.data;
            ADDR_PW_HI:   bank[v].pw[11:8]   <= req.data[3:0];
            ADDR_ATK_DEC: bank[v].atk_dec    <= req.data;
            ADDR_SUS_REL: bank[v].sus_rel    <= req.data;
            ADDR_CTRL: begin
              bank[v].ctrl   <= req.data;
              gate_rise_o[v] <= req.data[CTRL_GATE] & ~bank[v].ctrl[CTRL_GATE];
              gate_fall_o[v] <= ~req.data[CTRL_GATE] & bank[v].ctrl[CTRL_GATE];
            end
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
    assign freq_o[v*FREQ_W +: FREQ_W] = bank[v].freq;
    assign pw_o[v*PW_W +: PW_W]       = bank[v].pw;
    assign atk_dec_o[v*8 +: 8]        = bank[v].atk_dec;
    assign sus_rel_o[v*8 +: 8]        = bank[v].sus_rel;
    assign ctrl_o[v*8 +: 8]           = bank[v].ctrl;
  end

`ifdef SID_READBACK_EN
  logic [7:0] rd_dat;

  always_comb begin
    rd_dat = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (req.voice == VOICE_W'(v)) begin
        case (req.addr)
          ADDR_FREQ_LO: rd_dat = bank[v].freq[7:0];
          ADDR_FREQ_HI: rd_dat = bank[v].freq[15:8];
          ADDR_PW_LO:   rd_dat = bank[v].pw[7:0];
          ADDR_PW_HI:   rd_dat = {4'h0, bank[v].pw[11:8]};
          ADDR_ATK_DEC: rd_dat = bank[v].atk_dec;
          ADDR_SUS_REL: rd_dat = bank[v].sus_rel;
          ADDR_CTRL:    rd_dat = bank[v].ctrl;
          default:      rd_dat = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uio_oe  <= '0;
      uio_out <= '0;
    end else begin
      uio_oe  <= {8{rd_stb}};
      uio_out <= rd_stb ? rd_dat : 8'h00;
    end
  end
`else
  assign uio_out = '0;
  assign uio_oe  = '0;
`endif

endmodule
